// File: rtl/copy_writeback_regfile_pkg.sv
// Shared types and default sizes for the write-back register file slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, default DATA_W/ADDR_W/NREGS, write-back entry struct.
package copy_writeback_regfile_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_NREGS  = 4;
  localparam int DEF_ADDR_W = 2;

  // Clear sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One pending write-back at the default widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/copy_writeback_regfile_if.sv
// Execute-side bundle: write-back request handshake plus both read ports.
// Latency: n/a (wiring only); read data is combinational in the slave.
// Backpressure: master holds wb_valid/addr/data until wb_ready is seen high at an edge.
// Ports: wb_valid/wb_ready/wb_addr/wb_data, rd_addr1/rd_addr2 in, rd_data1/rd_data2 out.
interface copy_writeback_regfile_if
  import copy_writeback_regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  modport master (
    output wb_valid, wb_addr, wb_data, rd_addr1, rd_addr2,
    input  wb_ready, rd_data1, rd_data2
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, rd_addr1, rd_addr2,
    output wb_ready, rd_data1, rd_data2
  );

endinterface

// File: rtl/copy_writeback_regfile_wb_queue2.sv
// Two-entry in-order queue of pending write-backs; head always sits in slot 0.
// Latency: a push is visible on head/second the cycle after the edge it lands on.
// Backpressure: push is ignored when full, pop ignored when empty; caller gates both.
// Ports: clk, rst_n, push/push_entry, pop in; count, head, second (valid when count==2) out.
module copy_writeback_regfile_wb_queue2
  import copy_writeback_regfile_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  output logic [1:0] count,
  output entry_t     head,
  output entry_t     second
);

  entry_t     slot0;
  entry_t     slot1;
  logic [1:0] cnt;
  logic       push_eff;
  logic       pop_eff;
  logic [1:0] cnt_after_pop;

  assign push_eff      = push && (cnt != 2'd2);
  assign pop_eff       = pop && (cnt != 2'd0);
  assign cnt_after_pop = cnt - {1'b0, pop_eff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      // Pop shifts the younger entry forward; a push that lands in slot 0
      // (queue empty after the pop) overrides that shift.
      if (pop_eff) begin
        slot0 <= slot1;
      end
      if (push_eff && (cnt_after_pop == 2'd0)) begin
        slot0 <= push_entry;
      end
      if (push_eff && (cnt_after_pop == 2'd1)) begin
        slot1 <= push_entry;
      end
      cnt <= cnt_after_pop + {1'b0, push_eff};
    end
  end

  assign count  = cnt;
  assign head   = slot0;
  assign second = slot1;

endmodule

// File: rtl/copy_writeback_regfile.sv
// Write-back end of the Copy/ALU path: queue results, commit to a register array, serve bypassed reads, sequence clears.
// Latency: accepted at edge N -> readable via bypass after N, in the array after N+1 when commit_en is high.
// Backpressure: wb_ready low when the 2-entry queue is full, while busy/done clearing, or in reset.
// Ports: clk, rst_n; wb (slave: request handshake + two combinational read ports); commit_en, clr_req in; busy, clr_done out.
module copy_writeback_regfile
  import copy_writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  copy_writeback_regfile_if.slave  wb,
  input  logic                     commit_en,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [DATA_W-1:0] regs [NREGS];

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] clr_idx_nxt;
  logic              clr_wr;

  logic [1:0]        q_count;
  entry_t            q_head;
  entry_t            q_second;
  entry_t            q_push_entry;
  logic              accept;
  logic              commit;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NREGS;
  endfunction

  // Youngest pending write wins, then the older one, then the array.
  function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    if (in_range(a)) begin
      if ((q_count == 2'd2) && (q_second.addr == a)) begin
        r = q_second.data;
      end else if ((q_count != 2'd0) && (q_head.addr == a)) begin
        r = q_head.data;
      end else begin
        r = regs[a];
      end
    end
    return r;
  endfunction

  // rst_n is folded in so ready is low for the whole reset window.
  assign wb.wb_ready = (q_count != 2'd2) && (state == ST_IDLE) && rst_n;
  assign accept      = wb.wb_valid && wb.wb_ready;
  assign commit      = commit_en && (q_count != 2'd0) && !clr_wr;

  assign q_push_entry.addr = wb.wb_addr;
  assign q_push_entry.data = wb.wb_data;

  copy_writeback_regfile_wb_queue2 #(
    .entry_t (entry_t)
  ) u_wb_queue2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept),
    .push_entry (q_push_entry),
    .pop        (commit),
    .count      (q_count),
    .head       (q_head),
    .second     (q_second)
  );

  // Clearing only starts with an empty queue, so the two write sources never
  // collide; out-of-range commits are simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_wr) begin
      regs[clr_idx] <= '0;
    end else if (commit && in_range(q_head.addr)) begin
      regs[q_head.addr] <= q_head.data;
    end
  end

  assign wb.rd_data1 = rd_mux(wb.rd_addr1);
  assign wb.rd_data2 = rd_mux(wb.rd_addr2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clr_wr      = 1'b0;
    busy        = 1'b0;
    clr_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (q_count == 2'd0) begin
          state_nxt   = ST_CLEAR;
          clr_idx_nxt = '0;
        end
      end
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_wr = 1'b1;
        if (32'(clr_idx) == NREGS - 1) begin
          state_nxt   = ST_DONE;
          clr_idx_nxt = '0;
        end else begin
          clr_idx_nxt = clr_idx + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        clr_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_copy_writeback_regfile.sv
// Bench for copy_writeback_regfile: directed scenarios plus a randomized run
// against a queue/array reference model updated once per clock edge.
module tb_copy_writeback_regfile;

  localparam int DW = 4;
  localparam int NR = 4;
  localparam int AW = 2;

  localparam int M_IDLE  = 0;
  localparam int M_DRAIN = 1;
  localparam int M_CLEAR = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic commit_en = 1'b0;
  logic clr_req = 1'b0;
  logic busy;
  logic clr_done;

  copy_writeback_regfile_if #(.ADDR_W(AW), .DATA_W(DW)) wbif();

  copy_writeback_regfile #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (wbif),
    .commit_en (commit_en),
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_done  (clr_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int data;
  } m_ent_t;

  m_ent_t mq[$];
  int     mregs[NR];
  int     mmode;
  int     mcidx;

  function automatic void m_reset();
    mq.delete();
    for (int i = 0; i < NR; i++) mregs[i] = 0;
    mmode = M_IDLE;
    mcidx = 0;
  endfunction

  function automatic int m_read(int a);
    if (a >= NR) return 0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == a) return mq[i].data;
    end
    return mregs[a];
  endfunction

  function automatic bit m_ready();
    return (rst_n === 1'b1) && (mq.size() < 2) && (mmode == M_IDLE);
  endfunction

  task automatic drive(bit v, int a, int d, bit ce, bit cr);
    wbif.wb_valid = v;
    wbif.wb_addr  = AW'(a);
    wbif.wb_data  = DW'(d);
    commit_en     = ce;
    clr_req       = cr;
  endtask

  task automatic set_rd(int a1, int a2);
    wbif.rd_addr1 = AW'(a1);
    wbif.rd_addr2 = AW'(a2);
  endtask

  // Advance one clock edge and update the model with the inputs seen before it.
  task automatic tick();
    bit acc;
    bit com;
    bit cr;
    int a;
    int d;
    int nmode;
    acc = (wbif.wb_valid === 1'b1) && m_ready();
    com = (commit_en === 1'b1) && (mq.size() > 0);
    cr  = (clr_req === 1'b1);
    a   = int'(wbif.wb_addr);
    d   = int'(wbif.wb_data);
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      m_reset();
    end else begin
      nmode = mmode;
      case (mmode)
        M_IDLE:  if (cr) nmode = M_DRAIN;
        M_DRAIN: if (mq.size() == 0) begin nmode = M_CLEAR; mcidx = 0; end
        M_CLEAR: begin
          mregs[mcidx] = 0;
          if (mcidx == NR - 1) nmode = M_DONE;
          else mcidx++;
        end
        default: nmode = M_IDLE;
      endcase
      if (com) begin
        if (mq[0].addr < NR) mregs[mq[0].addr] = mq[0].data;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back('{addr: a, data: d});
      mmode = nmode;
    end
    #1;
  endtask

  task automatic test_reset();
    m_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    set_rd(1, 2);
    tick();
    @(negedge clk);
    checks++; if (wbif.wb_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", wbif.wb_ready); end
    checks++; if (busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, clr_done); end
    checks++; if (wbif.rd_data1 !== 4'h0 || wbif.rd_data2 !== 4'h0) begin errors++; $display("FAIL reset_rd got %h %h want 0 0", wbif.rd_data1, wbif.rd_data2); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wbif.wb_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", wbif.wb_ready); end
    checks++; if (busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL post_reset_flags got busy=%b done=%b want 0 0", busy, clr_done); end
    tick();
  endtask

  task automatic test_write_latency();
    set_rd(2, 2);
    drive(1, 2, 'hA, 1, 0);
    @(negedge clk);
    checks++; if (wbif.wb_ready !== 1'b1) begin errors++; $display("FAIL lat_ready got %b want 1", wbif.wb_ready); end
    tick();
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    checks++; if (wbif.rd_data1 !== 4'hA) begin errors++; $display("FAIL lat_bypass got %h want a", wbif.rd_data1); end
    tick();
    @(negedge clk);
    checks++; if (wbif.rd_data1 !== 4'hA || wbif.rd_data2 !== 4'hA) begin errors++; $display("FAIL lat_array got %h %h want a a", wbif.rd_data1, wbif.rd_data2); end
  endtask

  task automatic test_stall_bypass();
    set_rd(1, 2);
    drive(1, 1, 3, 0, 0);
    tick();
    drive(1, 1, 5, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (wbif.wb_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready got %b want 0", wbif.wb_ready); end
    checks++; if (wbif.rd_data1 !== 4'h5) begin errors++; $display("FAIL stall_young_bypass got %h want 5", wbif.rd_data1); end
    checks++; if (wbif.rd_data2 !== 4'hA) begin errors++; $display("FAIL stall_other_port got %h want a", wbif.rd_data2); end
    drive(0, 0, 0, 1, 0);
    tick();
    tick();
    @(negedge clk);
    checks++; if (wbif.rd_data1 !== 4'h5 || wbif.wb_ready !== 1'b1) begin errors++; $display("FAIL stall_drained got rd=%h rdy=%b want 5 1", wbif.rd_data1, wbif.wb_ready); end
  endtask

  task automatic test_clear();
    int pulses;
    for (int r = 0; r < NR; r++) begin
      drive(1, r, r + 1, 1, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 7, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    set_rd(0, 3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1 || wbif.wb_ready !== 1'b0) begin errors++; $display("FAIL drain_hold cyc %0d got busy=%b rdy=%b want 1 0", c, busy, wbif.wb_ready); end
      tick();
    end
    @(negedge clk);
    checks++; if (wbif.rd_data1 !== 4'h7 || wbif.rd_data2 !== 4'h4) begin errors++; $display("FAIL drain_bypass got %h %h want 7 4", wbif.rd_data1, wbif.rd_data2); end
    drive(0, 0, 0, 1, 0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      @(negedge clk);
      if (clr_done === 1'b1) pulses++;
      checks++; if (busy !== ((mmode == M_DRAIN) || (mmode == M_CLEAR)) || clr_done !== (mmode == M_DONE)) begin errors++; $display("FAIL clear_seq cyc %0d got busy=%b done=%b want %b %b", c, busy, clr_done, (mmode == M_DRAIN) || (mmode == M_CLEAR), mmode == M_DONE); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL clear_done_pulses got %0d want 1", pulses); end
    for (int r = 0; r < NR; r += 2) begin
      set_rd(r, r + 1);
      #1;
      checks++; if (wbif.rd_data1 !== 4'h0 || wbif.rd_data2 !== 4'h0) begin errors++; $display("FAIL clear_zero r%0d got %h %h want 0 0", r, wbif.rd_data1, wbif.rd_data2); end
    end
    checks++; if (wbif.wb_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL clear_idle got rdy=%b busy=%b want 1 0", wbif.wb_ready, busy); end
  endtask

  task automatic test_reset_mid_clear();
    for (int r = 0; r < NR; r++) begin
      drive(1, r, 9 + r, 1, 0);
      tick();
    end
    drive(0, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 1, 0);
    for (int c = 0; c < 20; c++) begin
      if (mmode == M_CLEAR && mcidx == 2) break;
      tick();
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midclr_busy got %b want 1", busy); end
    set_rd(3, 0);
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++; if (wbif.wb_ready !== 1'b0 || busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL midclr_reset_out got rdy=%b busy=%b done=%b want 0 0 0", wbif.wb_ready, busy, clr_done); end
    checks++; if (wbif.rd_data1 !== 4'h0 || wbif.rd_data2 !== 4'h0) begin errors++; $display("FAIL midclr_reset_rd got %h %h want 0 0", wbif.rd_data1, wbif.rd_data2); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wbif.wb_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midclr_release got rdy=%b busy=%b want 1 0", wbif.wb_ready, busy); end
    set_rd(1, 2);
    #1;
    checks++; if (wbif.rd_data1 !== 4'h0 || wbif.rd_data2 !== 4'h0) begin errors++; $display("FAIL midclr_regs got %h %h want 0 0", wbif.rd_data1, wbif.rd_data2); end
    tick();
  endtask

  task automatic test_same_edge();
    drive(1, 0, 6, 0, 0);
    tick();
    set_rd(3, 3);
    drive(1, 3, 'hD, 1, 0);
    tick();
    drive(1, 2, 1, 0, 0);
    @(negedge clk);
    checks++; if (wbif.rd_data1 !== 4'hD || wbif.rd_data2 !== 4'hD) begin errors++; $display("FAIL same_edge_bypass got %h %h want d d", wbif.rd_data1, wbif.rd_data2); end
    checks++; if (wbif.wb_ready !== 1'b1) begin errors++; $display("FAIL same_edge_count1 got rdy=%b want 1", wbif.wb_ready); end
    tick();
    drive(0, 0, 0, 0, 0);
    set_rd(0, 2);
    @(negedge clk);
    checks++; if (wbif.wb_ready !== 1'b0) begin errors++; $display("FAIL same_edge_count2 got rdy=%b want 0", wbif.wb_ready); end
    checks++; if (wbif.rd_data1 !== 4'h6 || wbif.rd_data2 !== 4'h1) begin errors++; $display("FAIL same_edge_head got %h %h want 6 1", wbif.rd_data1, wbif.rd_data2); end
    drive(0, 0, 0, 1, 0);
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, NR - 1), $urandom_range(0, 15),
            $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
      set_rd($urandom_range(0, NR - 1), $urandom_range(0, NR - 1));
      @(negedge clk);
      e1 = DW'(m_read(int'(wbif.rd_addr1)));
      e2 = DW'(m_read(int'(wbif.rd_addr2)));
      checks++; if (wbif.rd_data1 !== e1 || wbif.rd_data2 !== e2) begin errors++; $display("FAIL rand_rd cyc %0d got %h %h want %h %h", c, wbif.rd_data1, wbif.rd_data2, e1, e2); end
      checks++; if (wbif.wb_ready !== m_ready()) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", c, wbif.wb_ready, m_ready()); end
      checks++; if (busy !== ((mmode == M_DRAIN) || (mmode == M_CLEAR)) || clr_done !== (mmode == M_DONE)) begin errors++; $display("FAIL rand_fsm cyc %0d got busy=%b done=%b mode=%0d", c, busy, clr_done, mmode); end
      tick();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    set_rd(0, 0);
    test_reset();
    test_write_latency();
    test_stall_bypass();
    test_clear();
    test_reset_mid_clear();
    test_same_edge();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
